// File: rtl/add_seq_ctrl_if.sv
// add_seq_ctrl_if: requester-side handshake and operand/result bus for add_seq_ctrl.
// ADD_SEQ_OVF_EN adds the signed-overflow result bit ovf.
interface add_seq_ctrl_if #(parameter int CHUNK = 8, parameter int NCHUNK = 4);
   localparam int W = CHUNK * NCHUNK;
   logic start, sub, c_in, busy, done, c_out;
   logic [W-1:0] a, b, sum;
`ifdef ADD_SEQ_OVF_EN
   logic ovf;
   modport master (output start, sub, a, b, c_in, input busy, done, sum, c_out, ovf);
   modport slave (input start, sub, a, b, c_in, output busy, done, sum, c_out, ovf);
`else
   modport master (output start, sub, a, b, c_in, input busy, done, sum, c_out);
   modport slave (input start, sub, a, b, c_in, output busy, done, sum, c_out);
`endif
endinterface

// File: rtl/add_seq_ctrl.sv
// add_seq_ctrl: wide add/sub over one CHUNK-bit ripple slice, least-significant chunk first.
// Define ADD_SEQ_OVF_EN to also produce the signed-overflow flag ovf.
module add_seq_ctrl #(
   parameter int CHUNK = 8,
   parameter int NCHUNK = 4
) (
   input logic clk,
   input logic rst,
   add_seq_ctrl_if.slave bus
);
   localparam int W = CHUNK * NCHUNK;
   localparam int IW = NCHUNK > 1 ? $clog2(NCHUNK) : 1;
   localparam logic [IW-1:0] LAST = IW'(NCHUNK - 1);
   typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;
   state_t state;
   logic [IW-1:0] idx;
   logic [W-1:0] ra, rb, sum_r;
   logic cy, c_out_r, busy_r, done_r;
   logic [CHUNK-1:0] ca, cb;
   logic [CHUNK:0] slice;
   assign ca = ra[idx*CHUNK +: CHUNK];
   assign cb = rb[idx*CHUNK +: CHUNK];
   assign slice = {1'b0, ca} + {1'b0, cb} + {{CHUNK{1'b0}}, cy};
   assign bus.sum = sum_r;
   assign bus.c_out = c_out_r;
   assign bus.busy = busy_r;
   assign bus.done = done_r;
`ifdef ADD_SEQ_OVF_EN
   logic ovf_r;
   assign bus.ovf = ovf_r;
`endif
   always_ff @(posedge clk or posedge rst)
      if (rst) begin
         state <= IDLE;
         idx <= '0;
         ra <= '0;
         rb <= '0;
         sum_r <= '0;
         cy <= 1'b0;
         c_out_r <= 1'b0;
         busy_r <= 1'b0;
         done_r <= 1'b0;
`ifdef ADD_SEQ_OVF_EN
         ovf_r <= 1'b0;
`endif
      end else
         case (state)
            IDLE:
               if (bus.start) begin
                  ra <= bus.a;
                  // subtraction is A + ~B + 1
                  rb <= bus.sub ? ~bus.b : bus.b;
                  cy <= bus.sub | bus.c_in;
                  idx <= '0;
                  busy_r <= 1'b1;
                  state <= RUN;
               end
            RUN: begin
               sum_r[idx*CHUNK +: CHUNK] <= slice[CHUNK-1:0];
               cy <= slice[CHUNK];
               if (idx == LAST) begin
                  c_out_r <= slice[CHUNK];
`ifdef ADD_SEQ_OVF_EN
                  // carry into the MSB is recovered as sum ^ a ^ b at that bit
                  ovf_r <= slice[CHUNK] ^ slice[CHUNK-1] ^ ca[CHUNK-1] ^ cb[CHUNK-1];
`endif
                  idx <= '0;
                  done_r <= 1'b1;
                  state <= DONE;
               end else
                  idx <= idx + 1'b1;
            end
            default: begin
               done_r <= 1'b0;
               busy_r <= 1'b0;
               state <= IDLE;
            end
         endcase
endmodule

// File: tb/tb_add_seq_ctrl.sv
// tb_add_seq_ctrl: scoreboard bench for add_seq_ctrl; expected results queued at each accepting edge.
module tb_add_seq_ctrl;
   localparam int CHUNK = 8;
   localparam int NCHUNK = 4;
   localparam int W = CHUNK * NCHUNK;
   typedef struct {
      logic [W-1:0] sum;
      logic c_out;
      logic ovf;
      time t0;
   } exp_t;
   logic clk = 1'b0;
   logic rst = 1'b1;
   add_seq_ctrl_if #(.CHUNK(CHUNK), .NCHUNK(NCHUNK)) bus ();
   add_seq_ctrl #(.CHUNK(CHUNK), .NCHUNK(NCHUNK)) dut (.clk(clk), .rst(rst), .bus(bus));
   always #5 clk = ~clk;
   int errors = 0;
   int checks = 0;
   int bcnt = 0;
   bit chk_space = 0;
   time last_done = 0;
   logic [W-1:0] last_sum;
   exp_t q[$];
   exp_t mon_e;
   task automatic check(input string tag, input logic [63:0] act, input logic [63:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %0h expected %0h", tag, act, exp);
      end
   endtask
   task automatic push(input logic [W-1:0] a, input logic [W-1:0] b, input logic cin, input logic sub);
      logic [W-1:0] bb;
      logic [W:0] r;
      exp_t e;
      bb = sub ? ~b : b;
      r = {1'b0, a} + {1'b0, bb} + (W+1)'(sub | cin);
      e.sum = r[W-1:0];
      e.c_out = r[W];
      e.ovf = (a[W-1] == bb[W-1]) && (r[W-1] != a[W-1]);
      e.t0 = $time;
      last_sum = e.sum;
      q.push_back(e);
   endtask
   task automatic drain();
      for (int i = 0; i < 40 && q.size() != 0; i++) @(negedge clk);
      if (q.size() != 0) check("drain_timeout", 64'(q.size()), 0);
      @(negedge clk);
   endtask
   task automatic op(input logic [W-1:0] a, input logic [W-1:0] b, input logic cin, input logic sub);
      @(negedge clk);
      bus.a = a;
      bus.b = b;
      bus.c_in = cin;
      bus.sub = sub;
      bus.start = 1'b1;
      @(posedge clk);
      push(a, b, cin, sub);
      #1 bus.start = 1'b0;
      // operands churn during RUN; the captured values must win
      repeat (NCHUNK) begin
         bus.a = W'($urandom);
         bus.b = W'($urandom);
         bus.c_in = 1'($urandom);
         bus.sub = 1'($urandom);
         @(posedge clk);
         #1;
      end
      drain();
      repeat (2) @(negedge clk);
      check("sum_hold", 64'(bus.sum), 64'(last_sum));
   endtask
   always @(negedge clk)
      if (rst) bcnt = 0;
      else begin
         if (bus.busy) bcnt++;
         if (bus.done) begin
            if (q.size() == 0) check("spurious_done", 64'(bus.done), 0);
            else begin
               mon_e = q.pop_front();
               check("sum", 64'(bus.sum), 64'(mon_e.sum));
               check("c_out", 64'(bus.c_out), 64'(mon_e.c_out));
`ifdef ADD_SEQ_OVF_EN
               check("ovf", 64'(bus.ovf), 64'(mon_e.ovf));
`endif
               check("latency", 64'(($time - mon_e.t0 - 5) / 10), NCHUNK);
               check("busy_cycles", 64'(bcnt), NCHUNK + 1);
            end
            if (chk_space && last_done != 0) check("done_spacing", 64'(($time - last_done) / 10), NCHUNK + 2);
            last_done = $time;
            bcnt = 0;
         end
      end
   initial begin
      bus.start = 1'b0;
      bus.sub = 1'b0;
      bus.c_in = 1'b0;
      bus.a = '0;
      bus.b = '0;
      repeat (2) @(negedge clk);
      check("rst_busy", 64'(bus.busy), 0);
      check("rst_done", 64'(bus.done), 0);
      check("rst_sum", 64'(bus.sum), 0);
      check("rst_c_out", 64'(bus.c_out), 0);
      rst = 1'b0;
      op(32'h1234_5678, 32'h1111_1111, 1'b0, 1'b0);
      check("basic_sum", 64'(bus.sum), 64'h2345_6789);
      op(32'hFFFF_FFFF, 32'h0000_0000, 1'b1, 1'b0);
      check("ripple_c_out", 64'(bus.c_out), 1);
      op(32'd5, 32'd7, 1'b0, 1'b1);
      check("sub_sum", 64'(bus.sum), 64'hFFFF_FFFE);
      op(32'h8000_0000, 32'd1, 1'b0, 1'b1);
      check("sub2_sum", 64'(bus.sum), 64'h7FFF_FFFF);
      @(negedge clk);
      bus.a = 1;
      bus.b = 1;
      bus.c_in = 1'b0;
      bus.sub = 1'b0;
      bus.start = 1'b1;
      @(posedge clk);
      push(1, 1, 1'b0, 1'b0);
      #1 bus.start = 1'b0;
      @(posedge clk);
      #1 bus.start = 1'b1;
      bus.a = 9;
      bus.b = 9;
      @(posedge clk);
      #1 bus.start = 1'b0;
      drain();
      check("ignore_sum", 64'(bus.sum), 2);
      @(negedge clk);
      chk_space = 1;
      last_done = 0;
      bus.a = 32'h0F0F_0F0F;
      bus.b = 32'h7070_7070;
      bus.c_in = 1'b1;
      bus.start = 1'b1;
      @(posedge clk);
      push(32'h0F0F_0F0F, 32'h7070_7070, 1'b1, 1'b0);
      for (int i = 0; i < 3; i++) begin
         repeat (NCHUNK + 2) @(posedge clk);
         push(32'h0F0F_0F0F, 32'h7070_7070, 1'b1, 1'b0);
      end
      #1 bus.start = 1'b0;
      drain();
      chk_space = 0;
      for (int i = 0; i < 6; i++) op(W'($urandom), W'($urandom), 1'($urandom), 1'($urandom));
      @(negedge clk);
      bus.a = 32'hDEAD_BEEF;
      bus.b = 32'h1;
      bus.sub = 1'b0;
      bus.start = 1'b1;
      @(posedge clk);
      #1 bus.start = 1'b0;
      @(posedge clk);
      #3 rst = 1'b1;
      #1;
      check("abort_busy", 64'(bus.busy), 0);
      check("abort_done", 64'(bus.done), 0);
      check("abort_sum", 64'(bus.sum), 0);
      check("abort_c_out", 64'(bus.c_out), 0);
`ifdef ADD_SEQ_OVF_EN
      check("abort_ovf", 64'(bus.ovf), 0);
`endif
      @(negedge clk);
      rst = 1'b0;
      repeat (12) @(negedge clk);
      check("abort_idle", 64'(bus.busy), 0);
      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end
endmodule
